// File: rtl/slotmaker_ng.sv
// Virtual Apple II slot controller: card-ID table, $C0xx/$Cnxx/$C8xx decode into
// registered selects, $C800 expansion-ROM ownership, and a handshaked config port.
module slotmaker_ng #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned CARD_W    = 8,
    parameter logic [NUM_SLOTS*CARD_W-1:0] DEFAULT_CARDS = '0
) (
    input  logic              clk_logic,
    input  logic              reset_n,
    input  logic [15:0]       addr,
    input  logic              m2sel_n,
    input  logic              bus_strobe,
    input  logic              intcxrom,
    input  logic              intc8rom,
    input  logic [2:0]        cfg_slot,
    input  logic [CARD_W-1:0] cfg_card_i,
    input  logic              cfg_wr,
    input  logic              cfg_rd,
    output logic [CARD_W-1:0] cfg_card_o,
    output logic              cfg_ack,
    output logic [2:0]        slot_o,
    output logic [CARD_W-1:0] card_id_o,
    output logic              devselect_n,
    output logic              ioselect_n,
    output logic              iostrobe_n,
    output logic [2:0]        c8_owner_o,
    output logic              c8_valid_o
);

    logic [CARD_W-1:0] table_q [NUM_SLOTS];

    logic [2:0]        slot_q;
    logic [CARD_W-1:0] card_q;
    logic              dev_n_q, io_n_q, strb_n_q;
    logic [2:0]        owner_q;
    logic              valid_q;
    logic [CARD_W-1:0] cfg_card_q;
    logic              cfg_ack_q;

    logic              dev_hit, io_hit, c8_hit, cfff_hit;
    logic [2:0]        slot_d;
    logic [CARD_W-1:0] dec_card, tbl_cfg;
    logic              cfg_in_range;
    logic              dev_sel, io_sel, strb_sel;
    logic [2:0]        owner_d;
    logic              valid_d;
    logic [CARD_W-1:0] cfg_card_d;

    always_comb begin
        dev_hit  = !m2sel_n && (addr[15:7] == 9'h181);
        io_hit   = !m2sel_n && (addr[15:11] == 5'b11000) && (addr[10:8] != 3'd0);
        c8_hit   = !m2sel_n && (addr[15:11] == 5'b11001);
        cfff_hit = !m2sel_n && (addr == 16'hCFFF);

        slot_d = '0;
        if (dev_hit) begin
            slot_d = addr[6:4];
        end else if (io_hit) begin
            slot_d = addr[10:8];
        end else if (c8_hit) begin
            slot_d = owner_q;
        end

        // Unimplemented slots never match, so they read back as empty (ID 0).
        dec_card = '0;
        tbl_cfg  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slot_d == 3'(i)) dec_card = table_q[i];
            if (cfg_slot == 3'(i)) tbl_cfg = table_q[i];
        end
        cfg_in_range = {29'd0, cfg_slot} < NUM_SLOTS;

        dev_sel  = dev_hit && (dec_card != '0);
        io_sel   = io_hit && (dec_card != '0) && !intcxrom;
        strb_sel = c8_hit && valid_q && !intcxrom && !intc8rom;

        owner_d = owner_q;
        valid_d = valid_q;
        if (bus_strobe) begin
            if (io_sel) begin
                owner_d = slot_d;
                valid_d = 1'b1;
            end else if (cfff_hit) begin
                valid_d = 1'b0;
            end
        end
        // Release is checked against the post-claim owner so a same-cycle claim loses.
        if (cfg_wr && (cfg_slot == owner_d)) valid_d = 1'b0;

        cfg_card_d = cfg_card_q;
        if (cfg_wr || cfg_rd) begin
            if (!cfg_in_range) cfg_card_d = '0;
            else if (cfg_wr)   cfg_card_d = cfg_card_i;
            else               cfg_card_d = tbl_cfg;
        end
    end

    always_ff @(posedge clk_logic or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                table_q[i] <= DEFAULT_CARDS[i*CARD_W +: CARD_W];
            end
            slot_q     <= '0;
            card_q     <= '0;
            dev_n_q    <= 1'b1;
            io_n_q     <= 1'b1;
            strb_n_q   <= 1'b1;
            owner_q    <= '0;
            valid_q    <= 1'b0;
            cfg_card_q <= '0;
            cfg_ack_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_wr && (cfg_slot == 3'(i))) table_q[i] <= cfg_card_i;
            end
            slot_q     <= slot_d;
            card_q     <= dec_card;
            dev_n_q    <= !dev_sel;
            io_n_q     <= !io_sel;
            strb_n_q   <= !strb_sel;
            owner_q    <= owner_d;
            valid_q    <= valid_d;
            cfg_card_q <= cfg_card_d;
            cfg_ack_q  <= cfg_wr || cfg_rd;
        end
    end

    assign slot_o      = slot_q;
    assign card_id_o   = card_q;
    assign devselect_n = dev_n_q;
    assign ioselect_n  = io_n_q;
    assign iostrobe_n  = strb_n_q;
    assign c8_owner_o  = owner_q;
    assign c8_valid_o  = valid_q;
    assign cfg_card_o  = cfg_card_q;
    assign cfg_ack     = cfg_ack_q;

endmodule

// File: tb/tb_slotmaker_ng.sv
// Scoreboard bench for slotmaker_ng: an 8-slot and a 4-slot instance share stimulus,
// each held in reset while the other is exercised.
module tb_slotmaker_ng;

    typedef struct {
        int         cyc;
        logic [2:0] slot;
        logic [7:0] card;
        logic       dn, ion, sn;
        logic [2:0] own;
        logic       v;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] card;
    } cexp_t;

    logic        clk = 1'b0;
    logic        ra_n = 1'b0, rb_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        m2sel_n = 1'b1, bus_strobe = 1'b0, intcxrom = 1'b0, intc8rom = 1'b0;
    logic [2:0]  cfg_slot = 3'd0;
    logic [7:0]  cfg_card_i = 8'h00;
    logic        cfg_wr = 1'b0, cfg_rd = 1'b0;

    logic [7:0]  a_cfg, b_cfg, a_card, b_card;
    logic        a_ack, b_ack, a_dn, b_dn, a_ion, b_ion, a_sn, b_sn, a_v, b_v;
    logic [2:0]  a_slot, b_slot, a_own, b_own;

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;

    exp_t  qa[$], qb[$];
    cexp_t qca[$], qcb[$];

    slotmaker_ng #(
        .NUM_SLOTS(8), .CARD_W(8),
        .DEFAULT_CARDS(64'h05_00_00_02_00_00_00_00)
    ) dut_a (
        .clk_logic(clk), .reset_n(ra_n), .addr(addr), .m2sel_n(m2sel_n),
        .bus_strobe(bus_strobe), .intcxrom(intcxrom), .intc8rom(intc8rom),
        .cfg_slot(cfg_slot), .cfg_card_i(cfg_card_i), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_card_o(a_cfg), .cfg_ack(a_ack), .slot_o(a_slot), .card_id_o(a_card),
        .devselect_n(a_dn), .ioselect_n(a_ion), .iostrobe_n(a_sn),
        .c8_owner_o(a_own), .c8_valid_o(a_v)
    );

    slotmaker_ng #(
        .NUM_SLOTS(4), .CARD_W(8),
        .DEFAULT_CARDS(32'h00_03_00_00)
    ) dut_b (
        .clk_logic(clk), .reset_n(rb_n), .addr(addr), .m2sel_n(m2sel_n),
        .bus_strobe(bus_strobe), .intcxrom(intcxrom), .intc8rom(intc8rom),
        .cfg_slot(cfg_slot), .cfg_card_i(cfg_card_i), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_card_o(b_cfg), .cfg_ack(b_ack), .slot_o(b_slot), .card_id_o(b_card),
        .devselect_n(b_dn), .ioselect_n(b_ion), .iostrobe_n(b_sn),
        .c8_owner_o(b_own), .c8_valid_o(b_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change #1 after a rising edge; results appear on the next cycle's falling edge.
    task automatic go(input logic [15:0] a, input logic m2n, input logic stb,
                      input logic cx, input logic c8, input logic wr, input logic rd,
                      input logic [2:0] cs, input logic [7:0] cc);
        @(posedge clk);
        #1;
        addr = a; m2sel_n = m2n; bus_strobe = stb; intcxrom = cx; intc8rom = c8;
        cfg_wr = wr; cfg_rd = rd; cfg_slot = cs; cfg_card_i = cc;
    endtask

    task automatic idle();
        go(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic eb(input bit b, input int ofs, input logic [2:0] s, input logic [7:0] c,
                      input logic dn, input logic ion, input logic sn,
                      input logic [2:0] o, input logic v);
        exp_t e;
        e = '{cyc + ofs, s, c, dn, ion, sn, o, v};
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic ec(input bit b, input logic [7:0] c);
        cexp_t e;
        e = '{cyc + 1, c};
        if (b) qcb.push_back(e);
        else   qca.push_back(e);
    endtask

    task automatic chk_bus(input string tag, input exp_t e, input logic [2:0] s,
                           input logic [7:0] c, input logic dn, input logic ion,
                           input logic sn, input logic [2:0] o, input logic v);
        nvec++;
        if ({s, c, dn, ion, sn, o, v} !== {e.slot, e.card, e.dn, e.ion, e.sn, e.own, e.v}) begin
            nerr++;
            $display("FAIL %s cyc %0d: got slot=%0d card=%0d dev_n=%b io_n=%b strb_n=%b own=%0d valid=%b, expected slot=%0d card=%0d dev_n=%b io_n=%b strb_n=%b own=%0d valid=%b",
                     tag, cyc, s, c, dn, ion, sn, o, v,
                     e.slot, e.card, e.dn, e.ion, e.sn, e.own, e.v);
        end
    endtask

    task automatic chk_cfg(input string tag, input logic ack, input logic [7:0] card,
                           input bit b);
        cexp_t e;
        int    sz;
        sz = b ? qcb.size() : qca.size();
        if (ack) begin
            nvec++;
            if (sz != 0 && (b ? qcb[0].cyc : qca[0].cyc) == cyc) begin
                e = b ? qcb.pop_front() : qca.pop_front();
                if (card !== e.card) begin
                    nerr++;
                    $display("FAIL %s cyc %0d: got cfg_card_o=%0d, expected %0d", tag, cyc, card, e.card);
                end
            end else begin
                nerr++;
                $display("FAIL %s cyc %0d: got cfg_ack=1, expected 0", tag, cyc);
            end
        end else if (sz != 0 && (b ? qcb[0].cyc : qca[0].cyc) <= cyc) begin
            e = b ? qcb.pop_front() : qca.pop_front();
            nvec++;
            nerr++;
            $display("FAIL %s cyc %0d: got cfg_ack=0, expected 1 with card %0d", tag, cyc, e.card);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() != 0 && qa[0].cyc == cyc) begin
            e = qa.pop_front();
            chk_bus("bus_a", e, a_slot, a_card, a_dn, a_ion, a_sn, a_own, a_v);
        end
        if (qb.size() != 0 && qb[0].cyc == cyc) begin
            e = qb.pop_front();
            chk_bus("bus_b", e, b_slot, b_card, b_dn, b_ion, b_sn, b_own, b_v);
        end
        chk_cfg("cfg_a", a_ack, a_cfg, 1'b0);
        chk_cfg("cfg_b", b_ack, b_cfg, 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- 8-slot instance ----------------
        @(posedge clk);
        #1;
        eb(0, 0, 3'd0, 8'd0, 1, 1, 1, 3'd0, 0);
        @(negedge clk);
        #1;
        ra_n = 1'b1;

        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd4, 8'h00); eb(0, 1, 0, 0, 1, 1, 1, 0, 0); ec(0, 8'd2);
        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd3, 8'h00); eb(0, 1, 0, 0, 1, 1, 1, 0, 0); ec(0, 8'd0);
        idle();                                      eb(0, 1, 0, 0, 1, 1, 1, 0, 0);
        go(16'hC0C3, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 0, 1, 1, 0, 0);
        go(16'hC0B3, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 3, 0, 1, 1, 1, 0, 0);
        go(16'hC400, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 0, 1, 4, 1);
        go(16'hC900, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 1, 0, 4, 1);
        go(16'hCFFF, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 1, 0, 4, 0);
        go(16'hC900, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 1, 1, 4, 0);
        go(16'hC700, 0, 1, 1, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 7, 5, 1, 1, 1, 4, 0);
        go(16'hC400, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 0, 1, 4, 1);
        go(16'hC900, 0, 0, 0, 1, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 1, 1, 4, 1);
        go(16'hC900, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 1, 0, 4, 1);
        go(16'hC700, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 7, 5, 1, 0, 1, 7, 1);
        go(16'hC400, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 2, 1, 0, 1, 4, 1);
        go(16'hC400, 0, 1, 0, 0, 1, 0, 3'd4, 8'h00); eb(0, 1, 4, 2, 1, 0, 1, 4, 0); ec(0, 8'd0);
        go(16'hC0C0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 0, 1, 1, 1, 4, 0);
        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd4, 8'h00); eb(0, 1, 0, 0, 1, 1, 1, 4, 0); ec(0, 8'd0);
        go(16'h0000, 1, 0, 0, 0, 1, 1, 3'd4, 8'h09); eb(0, 1, 0, 0, 1, 1, 1, 4, 0); ec(0, 8'd9);
        idle();                                      eb(0, 1, 0, 0, 1, 1, 1, 4, 0);
        go(16'hC400, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 4, 9, 1, 0, 1, 4, 1);
        go(16'h0000, 1, 0, 0, 0, 1, 0, 3'd4, 8'h09); eb(0, 1, 0, 0, 1, 1, 1, 4, 0); ec(0, 8'd9);
        go(16'hC400, 1, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 0, 0, 1, 1, 1, 4, 0);
        go(16'hC700, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(0, 1, 7, 5, 1, 0, 1, 7, 1);
        go(16'hC800, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00);
        // Reset lands between edges: outputs must already be cleared at the falling edge.
        @(posedge clk);
        #1;
        ra_n = 1'b0;
        eb(0, 0, 0, 0, 1, 1, 1, 0, 0);
        @(negedge clk);
        #1;
        ra_n = 1'b1;
        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd4, 8'h00); eb(0, 1, 0, 0, 1, 1, 1, 0, 0); ec(0, 8'd2);
        idle();                                      eb(0, 1, 0, 0, 1, 1, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        ra_n = 1'b0;
        rb_n = 1'b1;

        // ---------------- 4-slot instance ----------------
        go(16'h0000, 1, 0, 0, 0, 1, 0, 3'd6, 8'h07); eb(1, 1, 0, 0, 1, 1, 1, 0, 0); ec(1, 8'd0);
        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd6, 8'h00); eb(1, 1, 0, 0, 1, 1, 1, 0, 0); ec(1, 8'd0);
        go(16'hC600, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(1, 1, 6, 0, 1, 1, 1, 0, 0);
        go(16'hC200, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00); eb(1, 1, 2, 3, 1, 0, 1, 2, 1);
        go(16'hC0E0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00); eb(1, 1, 6, 0, 1, 1, 1, 2, 1);
        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd2, 8'h00); eb(1, 1, 0, 0, 1, 1, 1, 2, 1); ec(1, 8'd3);
        go(16'h0000, 1, 0, 0, 0, 0, 1, 3'd4, 8'h00); eb(1, 1, 0, 0, 1, 1, 1, 2, 1); ec(1, 8'd0);
        idle();                                      eb(1, 1, 0, 0, 1, 1, 1, 2, 1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        if (qa.size() + qb.size() + qca.size() + qcb.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0",
                     qa.size() + qb.size() + qca.size() + qcb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
